multicycle_control_fsm: RTL

Moore-style main controller for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type (add/sub/or/nor/slt/sll/jr), beq, ori and j. It drives the 3-bit AluOp consumed by the ALU control unit and all datapath mux/write enables. A mem_ready handshake lets the memory stall any memory-access state.

---
 rtl/multicycle_control_fsm_pkg.sv | 48 ++++
 rtl/multicycle_control_fsm_if.sv | 37 +++
 rtl/multicycle_control_fsm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller:
// opcodes, funct codes, ALU/mux selects and the state enumeration.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_JR  = 6'd8;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_OR    = 3'd3;
  localparam logic [2:0] ALUOP_SLL   = 3'd4;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    JR        = 4'd10,
    ORI_EXEC  = 4'd11,
    ORI_WB    = 4'd12,
    HALT      = 4'd13
  } state_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// mux selects and write enables out.
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PcWrite;
  logic       PcWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IrWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       ExtOp;
  logic [1:0] PcSource;
  logic [2:0] AluOp;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, funct, mem_ready,
    output PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg,
           RegDst, RegWrite, AluSrcA, AluSrcB, ExtOp, PcSource, AluOp,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg,
           RegDst, RegWrite, AluSrcA, AluSrcB, ExtOp, PcSource, AluOp,
           instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore main controller for the multi-cycle MIPS datapath: state register,
// next-state logic and state-decoded control outputs.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W      = 4,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_fsm_if.master bus,
  output logic [STATE_W-1:0]   state_o
);

  state_t state, next;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next = FETCH;
    case (state)
      FETCH:     next = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next = MEM_ADDR;
          OP_RTYPE:     next = (bus.funct == FN_JR) ? JR : R_EXEC;
          OP_BEQ:       next = BRANCH;
          OP_J:         next = JUMP;
          OP_ORI:       next = ORI_EXEC;
          default:      next = ILLEGAL_HALT ? HALT : FETCH;
        endcase
      end
      MEM_ADDR:  next = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  next = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: next = bus.mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    next = R_WB;
      ORI_EXEC:  next = ORI_WB;
      HALT:      next = HALT;
      default:   next = FETCH;
    endcase
  end

  // Outputs are forced low while reset is high so an aborted access never writes.
  always_comb begin
    bus.PcWrite     = 1'b0;
    bus.PcWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IrWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.AluSrcA     = 1'b0;
    bus.AluSrcB     = SRCB_B;
    bus.ExtOp       = 1'b1;
    bus.PcSource    = PCSRC_ALU;
    bus.AluOp       = ALUOP_ADD;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    if (reset) begin
      bus.ExtOp = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.AluSrcB = SRCB_FOUR;
          bus.IrWrite = bus.mem_ready;
          bus.PcWrite = bus.mem_ready;
        end
        DECODE: begin
          bus.AluSrcB = SRCB_IMMSH;
          case (bus.opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ORI: bus.illegal_op = 1'b0;
            default:                                      bus.illegal_op = 1'b1;
          endcase
        end
        MEM_ADDR: begin
          bus.AluSrcA = 1'b1;
          bus.AluSrcB = SRCB_IMM;
        end
        MEM_READ: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEM_WB: begin
          bus.MemToReg   = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEM_WRITE: begin
          bus.MemWrite   = 1'b1;
          bus.IorD       = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        R_EXEC: begin
          bus.AluSrcA = 1'b1;
          bus.AluOp   = (bus.funct == FN_SLL) ? ALUOP_SLL : ALUOP_RTYPE;
        end
        R_WB: begin
          bus.RegDst     = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.AluSrcA     = 1'b1;
          bus.AluOp       = ALUOP_SUB;
          bus.PcWriteCond = 1'b1;
          bus.PcSource    = PCSRC_ALUOUT;
          bus.instr_done  = 1'b1;
        end
        JUMP: begin
          bus.PcWrite    = 1'b1;
          bus.PcSource   = PCSRC_JUMP;
          bus.instr_done = 1'b1;
        end
        JR: begin
          bus.PcWrite    = 1'b1;
          bus.PcSource   = PCSRC_REGA;
          bus.instr_done = 1'b1;
        end
        ORI_EXEC: begin
          bus.AluSrcA = 1'b1;
          bus.AluSrcB = SRCB_IMM;
          bus.ExtOp   = 1'b0;
          bus.AluOp   = ALUOP_OR;
        end
        ORI_WB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        HALT:    bus.ExtOp = 1'b0;
        default: ;
      endcase
    end
  end

  assign state_o = reset ? STATE_W'(FETCH) : STATE_W'(state);

endmodule
